// File: rtl/alu_exec_ctrl_if.sv
// Instruction issue channel between an upstream issuer and alu_exec_ctrl.
//
// Handshake: an instruction transfers on a rising clock edge where
// instr_valid and instr_ready are both high. The issuer must keep
// instr_valid and all instr_* payload fields stable until that edge.
// instr_ready may be high without instr_valid; no transfer occurs then.
//
// Signals:
//   instr_valid  issuer -> ctrl  instruction present
//   instr_ready  ctrl -> issuer  controller can accept (idle)
//   instr_op     issuer -> ctrl  ALU operation code
//   instr_rd     issuer -> ctrl  destination register address
//   instr_ra     issuer -> ctrl  operand-A register address
//   instr_rb     issuer -> ctrl  operand-B register address
//   instr_wb     issuer -> ctrl  1 = write result to rd, 0 = flags only
interface alu_exec_ctrl_if #(
  parameter int AW = 2
);
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_ra;
  logic [AW-1:0] instr_rb;
  logic          instr_wb;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_ra, instr_rb, instr_wb,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_ra, instr_rb, instr_wb,
    output instr_ready
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller placed in front of a combinational ALU.
// Accepts one instruction at a time, reads two operands from an internal
// register file, presents them to the ALU, captures the result, writes it
// back (optionally) and updates zero/negative flags.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   instr             instruction channel (slave side of alu_exec_ctrl_if)
//   ld_en/addr/data   external register load, honoured only when idle
//   rd_addr, rd_data  combinational debug read of the register file
//   alu_a/b/sel       registered ALU operands and operation select
//   alu_out           ALU result, sampled at the end of the EXEC cycle
//   done              one-cycle pulse during the write-back cycle
//   flag_z, flag_n    zero / negative flags of the last result
//   dbg_state         current FSM state (IDLE=0, READ=1, EXEC=2, WB=3)
module alu_exec_ctrl #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_exec_ctrl_if.slave   instr,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             done,
  output logic             flag_z,
  output logic             flag_n,
  output logic [1:0]       dbg_state
);

  localparam int NREG = 1 << AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rf_q [NREG];
  logic [2:0]       op_q;
  logic [AW-1:0]    rd_q, ra_q, rb_q;
  logic             wb_q;
  logic [WIDTH-1:0] opa_q, opb_q, res_q;
  // Separate from op_q so alu_sel only changes on entry to EXEC.
  logic [2:0]       sel_q;
  logic             flag_z_q, flag_n_q;
  logic             accept;

  assign accept = (state_q == S_IDLE) && instr.instr_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr.instr_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      wb_q     <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      sel_q    <= '0;
      res_q    <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // A load in the accept cycle lands before READ, so READ sees it.
      if (state_q == S_IDLE && ld_en) rf_q[ld_addr] <= ld_data;
      if (accept) begin
        op_q <= instr.instr_op;
        rd_q <= instr.instr_rd;
        ra_q <= instr.instr_ra;
        rb_q <= instr.instr_rb;
        wb_q <= instr.instr_wb;
      end
      if (state_q == S_READ) begin
        opa_q <= rf_q[ra_q];
        opb_q <= rf_q[rb_q];
        sel_q <= op_q;
      end
      if (state_q == S_EXEC) res_q <= alu_out;
      if (state_q == S_WB) begin
        if (wb_q) rf_q[rd_q] <= res_q;
        flag_z_q <= (res_q == '0);
        flag_n_q <= res_q[WIDTH-1];
      end
    end
  end

  assign instr.instr_ready = (state_q == S_IDLE);
  assign rd_data   = rf_q[rd_addr];
  assign alu_a     = opa_q;
  assign alu_b     = opb_q;
  assign alu_sel   = sel_q;
  assign done      = (state_q == S_WB);
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;
  assign dbg_state = state_q;

endmodule
